// File: rtl/msrv_32_branch_pkg.sv
// Shared encodings for the branch predict unit: opcodes, branch conditions,
// and the 2-bit saturating counter states held in the BHT.
package msrv_32_branch_pkg;

  localparam logic [4:0] OpcBranch = 5'b11000;
  localparam logic [4:0] OpcJal    = 5'b11011;
  localparam logic [4:0] OpcJalr   = 5'b11001;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  typedef enum logic [1:0] {
    CntSn = 2'b00,
    CntWn = 2'b01,
    CntWt = 2'b10,
    CntSt = 2'b11
  } bht_cnt_e;

  // Saturating step of a BHT counter toward the resolved direction.
  function automatic bht_cnt_e bht_cnt_next(input bht_cnt_e cur, input logic taken);
    bht_cnt_e nxt;
    nxt = cur;
    unique case (cur)
      CntSn: nxt = taken ? CntWn : CntSn;
      CntWn: nxt = taken ? CntWt : CntSn;
      CntWt: nxt = taken ? CntSt : CntWn;
      CntSt: nxt = taken ? CntSt : CntWt;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/msrv_32_branch_cmp.sv
// Combinational taken/not-taken decode for jumps and conditional branches.
module msrv_32_branch_cmp
  import msrv_32_branch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  output logic            taken_o,
  output logic            is_cond_o
);

  logic eq, lt_s, lt_u;

  assign eq   = (rs1_i == rs2_i);
  assign lt_s = ($signed(rs1_i) < $signed(rs2_i));
  assign lt_u = (rs1_i < rs2_i);

  always_comb begin
    taken_o   = 1'b0;
    is_cond_o = (opcode_i == OpcBranch);
    case (opcode_i)
      OpcJal, OpcJalr: taken_o = 1'b1;
      OpcBranch: begin
        case (funct3_i)
          F3Beq:   taken_o = eq;
          F3Bne:   taken_o = ~eq;
          F3Blt:   taken_o = lt_s;
          F3Bge:   taken_o = ~lt_s;
          F3Bltu:  taken_o = lt_u;
          F3Bgeu:  taken_o = ~lt_u;
          default: taken_o = 1'b0;
        endcase
      end
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/msrv_32_branch_predict_unit.sv
// Bimodal branch predictor: PC-indexed 2-bit counter BHT with one-cycle lookup,
// one-cycle resolve and a saturating mispredict counter.
module msrv_32_branch_predict_unit
  import msrv_32_branch_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             ms_riscv32_mp_clk_in,
  input  logic             ms_riscv32_mp_rst_in,
  input  logic             flush_in,
  input  logic             lookup_valid_in,
  input  logic [XLEN-1:0]  lookup_pc_in,
  output logic             predict_valid_out,
  output logic             predict_taken_out,
  input  logic             resolve_valid_in,
  input  logic [XLEN-1:0]  resolve_pc_in,
  input  logic [XLEN-1:0]  rs1_in,
  input  logic [XLEN-1:0]  rs2_in,
  input  logic [4:0]       opcode_6_to_2_in,
  input  logic [2:0]       funct3_in,
  input  logic             predicted_taken_in,
  output logic             resolve_valid_out,
  output logic             branch_taken_out,
  output logic             mispredict_out,
  output logic [CNT_W-1:0] mispredict_count_out
);

  localparam int unsigned IdxW = $clog2(BHT_DEPTH);

  logic [IdxW-1:0] lookup_idx, resolve_idx;
  logic            br_taken, br_is_cond;
  logic            res_ok;
  logic            bht_we;

  bht_cnt_e        bht_q [BHT_DEPTH];
  bht_cnt_e        bht_d [BHT_DEPTH];

  logic             predict_valid_q, predict_valid_d;
  logic             predict_taken_q, predict_taken_d;
  logic             resolve_valid_q, resolve_valid_d;
  logic             branch_taken_q, branch_taken_d;
  logic             mispredict_q, mispredict_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  assign lookup_idx  = lookup_pc_in[IdxW+1:2];
  assign resolve_idx = resolve_pc_in[IdxW+1:2];

  // Only the index bits of the PCs take part in prediction.
  logic unused_pc;
  assign unused_pc = ^{lookup_pc_in[XLEN-1:IdxW+2], lookup_pc_in[1:0],
                       resolve_pc_in[XLEN-1:IdxW+2], resolve_pc_in[1:0]};

  msrv_32_branch_cmp #(
    .XLEN(XLEN)
  ) u_cmp (
    .rs1_i     (rs1_in),
    .rs2_i     (rs2_in),
    .opcode_i  (opcode_6_to_2_in),
    .funct3_i  (funct3_in),
    .taken_o   (br_taken),
    .is_cond_o (br_is_cond)
  );

  assign res_ok = resolve_valid_in & ~flush_in;
  assign bht_we = res_ok & br_is_cond;

  always_comb begin
    predict_valid_d = lookup_valid_in;
    // Reads bht_q, so a same-cycle update to this index is not yet visible.
    predict_taken_d = bht_q[lookup_idx][1];
    resolve_valid_d = res_ok;
    branch_taken_d  = res_ok & br_taken;
    mispredict_d    = res_ok & (br_taken ^ predicted_taken_in);
    mis_cnt_d       = mis_cnt_q;
    if (mispredict_d && (mis_cnt_q != {CNT_W{1'b1}})) begin
      mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    bht_d = bht_q;
    if (bht_we) begin
      bht_d[resolve_idx] = bht_cnt_next(bht_q[resolve_idx], br_taken);
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      predict_valid_q <= 1'b0;
      predict_taken_q <= 1'b0;
      resolve_valid_q <= 1'b0;
      branch_taken_q  <= 1'b0;
      mispredict_q    <= 1'b0;
      mis_cnt_q       <= '0;
      for (int i = 0; i < int'(BHT_DEPTH); i++) begin
        bht_q[i] <= CntWn;
      end
    end else begin
      predict_valid_q <= predict_valid_d;
      predict_taken_q <= predict_taken_d;
      resolve_valid_q <= resolve_valid_d;
      branch_taken_q  <= branch_taken_d;
      mispredict_q    <= mispredict_d;
      mis_cnt_q       <= mis_cnt_d;
      bht_q           <= bht_d;
    end
  end

  assign predict_valid_out    = predict_valid_q;
  assign predict_taken_out    = predict_taken_q;
  assign resolve_valid_out    = resolve_valid_q;
  assign branch_taken_out     = branch_taken_q;
  assign mispredict_out       = mispredict_q;
  assign mispredict_count_out = mis_cnt_q;

endmodule

// File: tb/tb_msrv_32_branch_predict_unit.sv
// Directed and randomized checks of the branch predict unit against an
// array-based reference model; a CNT_W=2 copy shares the stimulus.
module tb_msrv_32_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        lv = 1'b0;
  logic [31:0] lpc = '0;
  logic        rv = 1'b0;
  logic [31:0] rpc = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [4:0]  opc = '0;
  logic [2:0]  f3 = '0;
  logic        pt = 1'b0;

  logic        pv1, ptk1, rvo1, bt1, mp1;
  logic [15:0] cnt1;
  logic        pv2, ptk2, rvo2, bt2, mp2;
  logic [1:0]  cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  int bht_m [64];
  int cnt_m1, cnt_m2;

  always #5 clk = ~clk;

  msrv_32_branch_predict_unit dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .flush_in             (flush),
    .lookup_valid_in      (lv),
    .lookup_pc_in         (lpc),
    .predict_valid_out    (pv1),
    .predict_taken_out    (ptk1),
    .resolve_valid_in     (rv),
    .resolve_pc_in        (rpc),
    .rs1_in               (rs1),
    .rs2_in               (rs2),
    .opcode_6_to_2_in     (opc),
    .funct3_in            (f3),
    .predicted_taken_in   (pt),
    .resolve_valid_out    (rvo1),
    .branch_taken_out     (bt1),
    .mispredict_out       (mp1),
    .mispredict_count_out (cnt1)
  );

  msrv_32_branch_predict_unit #(
    .CNT_W(2)
  ) dut2 (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .flush_in             (flush),
    .lookup_valid_in      (lv),
    .lookup_pc_in         (lpc),
    .predict_valid_out    (pv2),
    .predict_taken_out    (ptk2),
    .resolve_valid_in     (rv),
    .resolve_pc_in        (rpc),
    .rs1_in               (rs1),
    .rs2_in               (rs2),
    .opcode_6_to_2_in     (opc),
    .funct3_in            (f3),
    .predicted_taken_in   (pt),
    .resolve_valid_out    (rvo2),
    .branch_taken_out     (bt2),
    .mispredict_out       (mp2),
    .mispredict_count_out (cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Architectural branch outcome computed from signed/unsigned integer values.
  function automatic bit model_taken(input logic [4:0] op, input logic [2:0] fn,
                                     input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, sb;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[31] ? ua - 64'sd4294967296 : ua;
    sb = b[31] ? ub - 64'sd4294967296 : ub;
    if (op == 5'b11011 || op == 5'b11001) return 1'b1;
    if (op != 5'b11000) return 1'b0;
    case (fn)
      3'd0: return ua == ub;
      3'd1: return ua != ub;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return ua < ub;
      3'd7: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) bht_m[i] = 1;
    cnt_m1 = 0;
    cnt_m2 = 0;
  endtask

  // One clock: drive inputs, predict from the model, clock, compare at +1.
  task automatic step(input bit r, input bit fl, input bit l_v, input logic [31:0] l_pc,
                      input bit r_v, input logic [31:0] r_pc, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] op, input logic [2:0] fn,
                      input bit p);
    int li, ri;
    bit tk, ok, mp, e_pv, e_pt, e_rv, e_bt;
    rst = r; flush = fl; lv = l_v; lpc = l_pc; rv = r_v; rpc = r_pc;
    rs1 = a; rs2 = b; opc = op; f3 = fn; pt = p;
    li = int'(l_pc >> 2) % 64;
    ri = int'(r_pc >> 2) % 64;
    tk = model_taken(op, fn, a, b);
    ok = r_v && !fl;
    mp = ok && (tk != p);
    if (r) begin
      e_pv = 0; e_pt = 0; e_rv = 0; e_bt = 0; mp = 0;
      model_reset();
    end else begin
      e_pv = l_v;
      e_pt = (bht_m[li] >= 2);
      e_rv = ok;
      e_bt = tk;
      if (ok && op == 5'b11000) begin
        if (tk) bht_m[ri] = (bht_m[ri] == 3) ? 3 : bht_m[ri] + 1;
        else    bht_m[ri] = (bht_m[ri] == 0) ? 0 : bht_m[ri] - 1;
      end
      if (mp && cnt_m1 < 65535) cnt_m1++;
      if (mp && cnt_m2 < 3) cnt_m2++;
    end
    @(posedge clk);
    #1;
    check("predict_valid", 32'(pv1), 32'(e_pv));
    if (l_v || r) check("predict_taken", 32'(ptk1), 32'(e_pt));
    check("resolve_valid", 32'(rvo1), 32'(e_rv));
    if (ok || r) check("branch_taken", 32'(bt1), 32'(e_bt));
    check("mispredict", 32'(mp1), 32'(mp));
    check("mis_count", 32'(cnt1), 32'(cnt_m1));
    check("mis_count_w2", 32'(cnt2), 32'(cnt_m2));
    check("mispredict_w2", 32'(mp2), 32'(mp));
  endtask

  initial begin
    logic [31:0] a, b, l_pc, r_pc;
    logic [4:0]  op;
    int          sel;

    model_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Fresh table predicts weakly not-taken.
    step(0, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    check("reset_wn_lookup", 32'(ptk1), 32'd0);

    // BEQ taken three times trains the counter to strongly taken.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 32'h100, 5, 5, 5'b11000, 3'b000, 0);
    check("beq_count3", 32'(cnt1), 32'd3);
    step(0, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    check("beq_trained", 32'(ptk1), 32'd1);

    step(0, 0, 0, 0, 1, 32'h200, 32'hFFFF_FFFF, 1, 5'b11000, 3'b100, 0);
    check("blt_signed", 32'(bt1), 32'd1);
    step(0, 0, 0, 0, 1, 32'h200, 32'hFFFF_FFFF, 1, 5'b11000, 3'b110, 0);
    check("bltu_unsigned", 32'(bt1), 32'd0);

    step(0, 0, 0, 0, 1, 32'h300, 0, 0, 5'b11011, 0, 0);
    check("jal_mispredict", 32'(mp1), 32'd1);
    step(0, 0, 1, 32'h300, 0, 0, 0, 0, 0, 0, 0);

    // Flushed mispredicting BNE leaves everything untouched.
    step(0, 1, 0, 0, 1, 32'h100, 1, 2, 5'b11000, 3'b001, 0);
    check("flush_rv", 32'(rvo1), 32'd0);
    step(0, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 32'h400, 0, 0, 5'b11001, 0, 0);
    check("cnt_w2_sat", 32'(cnt2), 32'd3);

    // Reset overrides a concurrent flush and update.
    step(1, 1, 1, 32'h100, 1, 32'h100, 3, 3, 5'b11000, 3'b000, 0);
    check("rst_count", 32'(cnt1), 32'd0);
    step(0, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    check("rst_bht_wn", 32'(ptk1), 32'd0);
    step(0, 0, 0, 0, 1, 32'h100, 7, 7, 5'b11000, 3'b000, 1);
    step(0, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 2000; n++) begin
      a = $urandom;
      sel = $urandom_range(0, 2);
      b = (sel == 0) ? a : (sel == 1) ? 32'($urandom) : a + 32'($urandom_range(0, 2)) - 1;
      sel = $urandom_range(0, 7);
      op = (sel < 4) ? 5'b11000 : (sel == 4) ? 5'b11011 : (sel == 5) ? 5'b11001 :
           5'($urandom);
      l_pc = {$urandom_range(0, 3) == 0 ? 24'($urandom) : 24'h0, 2'b0,
              3'($urandom_range(0, 7)), 3'($urandom)};
      r_pc = {$urandom_range(0, 3) == 0 ? 24'($urandom) : 24'h0, 2'b0,
              3'($urandom_range(0, 7)), 3'($urandom)};
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
           1'($urandom), l_pc, ($urandom_range(0, 3) != 0), r_pc, a, b, op,
           3'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/msrv_32_branch_predict_unit.md
MSRV_32_BRANCH_PREDICT_UNIT -- requirements
Module: msrv_32_branch_predict_unit

Interface
REQ-001 Parameter XLEN, default 32: operand width in bits.
REQ-002 Parameter BHT_DEPTH, default 64: branch history table entries; a power of two, at least 4.
REQ-003 Parameter CNT_W, default 16: width of the mispredict counter.
REQ-004 ms_riscv32_mp_clk_in  input  1  the single clock; all state updates on the rising edge.
REQ-005 ms_riscv32_mp_rst_in  input  1  synchronous, active-high reset.
REQ-006 flush_in  input  1  squashes the in-flight resolve result.
REQ-007 lookup_valid_in  input  1  fetch-side prediction request.
REQ-008 lookup_pc_in  input  XLEN  fetch PC.
REQ-009 predict_valid_out  output  1  prediction valid, one cycle after the request.
REQ-010 predict_taken_out  output  1  predicted direction.
REQ-011 resolve_valid_in  input  1  control-flow instruction presented for resolution.
REQ-012 resolve_pc_in  input  XLEN  PC of the resolving instruction.
REQ-013 rs1_in, rs2_in  input  XLEN each  source operands.
REQ-014 opcode_6_to_2_in  input  5  opcode bits 6:2.
REQ-015 funct3_in  input  3  branch condition.
REQ-016 predicted_taken_in  input  1  prediction carried with the instruction.
REQ-017 resolve_valid_out  output  1  resolve result valid.
REQ-018 branch_taken_out  output  1  actual direction.
REQ-019 mispredict_out  output  1  actual direction differs from the prediction.
REQ-020 mispredict_count_out  output  CNT_W  saturating count of mispredicts.

Function
REQ-021 BHT index SHALL be PC[IDX_W+1:2], where IDX_W = log2(BHT_DEPTH); each entry SHALL be a 2-bit saturating counter (00 SN, 01 WN, 10 WT, 11 ST).
REQ-022 Lookup latency SHALL be 1 cycle: predict_valid_out = registered lookup_valid_in; predict_taken_out = registered MSB of the indexed counter.
REQ-023 Taken decode: opcode 11011 (JAL) and 11001 (JALR) SHALL always be taken; opcode 11000 SHALL decode funct3 as 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU; funct3 010/011 and all other opcodes SHALL be not taken.
REQ-024 Resolve latency SHALL be 1 cycle: resolve_valid_out, branch_taken_out and mispredict_out SHALL be registered from the inputs of the resolve cycle.
REQ-025 mispredict_out SHALL be branch_taken XOR predicted_taken_in, gated by resolve validity.
REQ-026 BHT update: only for opcode 11000 with resolve_valid_in=1 and flush_in=0; increment on taken, decrement on not taken; saturate at 11 and at 00.
REQ-027 JAL/JALR SHALL NOT update the BHT, but SHALL assert mispredict_out when predicted_taken_in=0.
REQ-028 Same-index lookup and update in one cycle: the lookup SHALL return the pre-update counter value.
REQ-029 flush_in=1 SHALL force resolve_valid_out=0 and mispredict_out=0 on the next cycle, suppress the BHT update and the counter increment, and leave lookup unaffected.
REQ-030 mispredict_count_out SHALL increment by 1 per unflushed mispredict and hold at 2^CNT_W-1.
REQ-031 Signed compares SHALL use XLEN-bit two's complement; unsigned compares SHALL use the full XLEN-bit magnitude.

Reset
REQ-032 While reset is high, all outputs SHALL be 0 on the next edge and every BHT entry SHALL become 01.
REQ-033 A reset asserted mid-operation SHALL discard in-flight results and take priority over flush_in and over a concurrent update.

Structure
REQ-034 Opcode values (11000, 11011, 11001), funct3 codes and counter-state encodings SHALL live in the shared package msrv_32_branch_pkg.
REQ-035 Condition evaluation (REQ-023, REQ-031) SHALL be a combinational sub-module, msrv_32_branch_cmp.
REQ-036 The BHT SHALL be a flop array reset per REQ-032, with no RAM macro.

Verification
REQ-037 Reset, then lookup PC 0x100 -> 1 cycle later predict_valid_out=1, predict_taken_out=0 (WN).
REQ-038 Three resolves of BEQ at PC 0x100 with rs1=rs2=5, each predicted 0 -> mispredict_out=1 each time; counter 01->10->11->11; mispredict_count_out=3; a following lookup of 0x100 -> taken=1.
REQ-039 BLT with rs1=0xFFFFFFFF, rs2=1 -> taken=1; BLTU with the same operands -> taken=0.
REQ-040 JAL with predicted_taken_in=0 -> branch_taken_out=1, mispredict_out=1, BHT unchanged.
REQ-041 A mispredicting BNE with flush_in=1 -> resolve_valid_out=0, count unchanged, counter unchanged.
REQ-042 CNT_W=2 with 5 mispredicts -> mispredict_count_out holds at 3; reset mid-stream -> all outputs 0 and the BHT returns to 01.
